// File: rtl/wb_stage_if.sv
// MEM -> WB bus bundle for wb_stage: pipeline fields coming out of MEM, the
// data-memory response, and the register-file write port toward decode.
// Optional bypass signals are present only when WB_BYPASS_EN is defined.
interface wb_stage_if #(parameter int NBits = 32);
    logic             in_valid;
    logic             flush;
    logic             in_RegWrite;
    logic             in_MemtoReg;
    logic             in_ALUMemOrPC;
    logic [4:0]       in_WriteRegister;
    logic [NBits-1:0] in_ALUResult;
    logic [NBits-1:0] in_PCPlus4;
    logic [NBits-1:0] MemReadData;
    logic             MemReadValid;
    logic             out_RegWrite;
    logic [4:0]       out_WriteRegister;
    logic [NBits-1:0] out_WriteData;
    logic             out_ALUMemOrPC;
    logic             Stall;
    logic             LoadError;
`ifdef WB_BYPASS_EN
    logic [4:0]       ReadRegister1;
    logic [4:0]       ReadRegister2;
    logic [NBits-1:0] ReadData1In;
    logic [NBits-1:0] ReadData2In;
    logic [NBits-1:0] ReadData1Bypass;
    logic [NBits-1:0] ReadData2Bypass;
`endif

    // Pipeline side (MEM stage / memory / decode read port)
    modport master (
        output in_valid, flush, in_RegWrite, in_MemtoReg, in_ALUMemOrPC,
               in_WriteRegister, in_ALUResult, in_PCPlus4, MemReadData, MemReadValid,
`ifdef WB_BYPASS_EN
        output ReadRegister1, ReadRegister2, ReadData1In, ReadData2In,
        input  ReadData1Bypass, ReadData2Bypass,
`endif
        input  out_RegWrite, out_WriteRegister, out_WriteData, out_ALUMemOrPC,
               Stall, LoadError
    );

    // Write-back stage side
    modport slave (
        input  in_valid, flush, in_RegWrite, in_MemtoReg, in_ALUMemOrPC,
               in_WriteRegister, in_ALUResult, in_PCPlus4, MemReadData, MemReadValid,
`ifdef WB_BYPASS_EN
        input  ReadRegister1, ReadRegister2, ReadData1In, ReadData2In,
        output ReadData1Bypass, ReadData2Bypass,
`endif
        output out_RegWrite, out_WriteRegister, out_WriteData, out_ALUMemOrPC,
               Stall, LoadError
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back select for the 32-bit MIPS core.
// Holds the pipeline while a load waits on variable-latency memory and
// abandons the load (sticky LoadError) after LOAD_TIMEOUT wait cycles.
// Optional macro WB_BYPASS_EN adds a same-cycle write->read register bypass.
module wb_stage #(
    parameter int NBits        = 32,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, WAIT_LOAD} state_t;

    state_t           state;
    logic [7:0]       wait_cnt;
    logic             wb_RegWrite;
    logic             wb_ALUMemOrPC;
    logic [4:0]       wb_WriteRegister;
    logic [NBits-1:0] wb_PCPlus4;
    logic             captured_valid;

    assign captured_valid = bus.in_valid & ~bus.flush;

    // Waiting on load data freezes everything upstream.
    assign bus.Stall = (state == WAIT_LOAD);

    // Capture, FSM and registered write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            wait_cnt              <= '0;
            wb_RegWrite           <= 1'b0;
            wb_ALUMemOrPC         <= 1'b0;
            wb_WriteRegister      <= '0;
            wb_PCPlus4            <= '0;
            bus.out_RegWrite      <= 1'b0;
            bus.out_WriteRegister <= '0;
            bus.out_WriteData     <= '0;
            bus.out_ALUMemOrPC    <= 1'b0;
            bus.LoadError         <= 1'b0;
        end else if (state != WAIT_LOAD) begin
            // Fields are held so a delayed load can still retire them.
            wb_RegWrite      <= bus.in_RegWrite;
            wb_ALUMemOrPC    <= bus.in_ALUMemOrPC;
            wb_WriteRegister <= bus.in_WriteRegister;
            wb_PCPlus4       <= bus.in_PCPlus4;
            if (!captured_valid) begin
                state            <= IDLE;
                bus.out_RegWrite <= 1'b0;
            end else if (bus.in_MemtoReg && !bus.MemReadValid) begin
                state            <= WAIT_LOAD;
                wait_cnt         <= '0;
                bus.out_RegWrite <= 1'b0;
            end else begin
                state                 <= WRITE;
                // r0 is never written, except that a link always targets r31.
                bus.out_RegWrite      <= bus.in_RegWrite &
                                         ((bus.in_WriteRegister != 5'd0) | bus.in_ALUMemOrPC);
                bus.out_WriteRegister <= bus.in_WriteRegister;
                bus.out_ALUMemOrPC    <= bus.in_ALUMemOrPC;
                bus.out_WriteData     <= bus.in_ALUMemOrPC ? bus.in_PCPlus4 :
                                         bus.in_MemtoReg   ? bus.MemReadData :
                                                             bus.in_ALUResult;
            end
        end else begin
            // Load is past commit: flush and new MEM contents are ignored here.
            if (bus.MemReadValid) begin
                state                 <= WRITE;
                bus.out_RegWrite      <= wb_RegWrite &
                                         ((wb_WriteRegister != 5'd0) | wb_ALUMemOrPC);
                bus.out_WriteRegister <= wb_WriteRegister;
                bus.out_ALUMemOrPC    <= wb_ALUMemOrPC;
                bus.out_WriteData     <= wb_ALUMemOrPC ? wb_PCPlus4 : bus.MemReadData;
            end else if (wait_cnt == 8'(LOAD_TIMEOUT - 1)) begin
                state         <= IDLE;
                bus.LoadError <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [4:0] eff_dest;

    // Link writes land in r31 regardless of the encoded destination.
    assign eff_dest = bus.out_ALUMemOrPC ? 5'd31 : bus.out_WriteRegister;

    assign bus.ReadData1Bypass = (bus.out_RegWrite && bus.ReadRegister1 != 5'd0 &&
                                  eff_dest == bus.ReadRegister1) ? bus.out_WriteData
                                                                 : bus.ReadData1In;
    assign bus.ReadData2Bypass = (bus.out_RegWrite && bus.ReadRegister2 != 5'd0 &&
                                  eff_dest == bus.ReadRegister2) ? bus.out_WriteData
                                                                 : bus.ReadData2In;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios from the test plan plus
// a randomized instruction stream checked against a per-instruction model.
module tb_wb_stage;
    localparam int TO = 15;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_reg  = '0;

    wb_stage_if #(.NBits(32)) bus();

    wb_stage #(.NBits(32), .LOAD_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.in_valid = 0; bus.flush = 0; bus.in_RegWrite = 0; bus.in_MemtoReg = 0;
        bus.in_ALUMemOrPC = 0; bus.in_WriteRegister = 0; bus.in_ALUResult = 0;
        bus.in_PCPlus4 = 0; bus.MemReadData = 0; bus.MemReadValid = 0;
    endtask

    // Present one instruction at a negedge, service its load delay d, and check
    // the retirement against the architectural rules.
    task automatic run_instr(input string tag, input logic v, input logic fl,
                             input logic rw, input logic m2r, input logic lk,
                             input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] pc4, input logic [31:0] ld, input int d);
        logic        retire, we;
        logic [31:0] data;
        retire = v & ~fl;
        we     = retire & rw & ((rd != 0) | lk);
        data   = lk ? pc4 : (m2r ? ld : alu);
        bus.in_valid = v; bus.flush = fl; bus.in_RegWrite = rw; bus.in_MemtoReg = m2r;
        bus.in_ALUMemOrPC = lk; bus.in_WriteRegister = rd; bus.in_ALUResult = alu;
        bus.in_PCPlus4 = pc4;
        if (retire && m2r) begin
            bus.MemReadValid = (d == 0);
            bus.MemReadData  = (d == 0) ? ld : $urandom;
        end else begin
            bus.MemReadValid = 1'($urandom);
            bus.MemReadData  = $urandom;
        end
        @(posedge clk); @(negedge clk);
        if (retire && m2r && d > 0) begin
            for (int k = 1; k <= d; k++) begin
                tests++;
                if ({bus.Stall, bus.out_RegWrite} !== 2'b10) begin
                    fails++;
                    $display("FAIL %s wait%0d stall/we got %b%b need 10", tag, k, bus.Stall, bus.out_RegWrite);
                end
                // Upstream junk while stalled must not be captured.
                bus.in_valid = 1'($urandom); bus.flush = 1'($urandom);
                bus.in_WriteRegister = 5'($urandom); bus.in_ALUResult = $urandom;
                bus.MemReadValid = (k == d);
                bus.MemReadData  = (k == d) ? ld : $urandom;
                @(posedge clk); @(negedge clk);
            end
        end
        if (retire) begin
            last_data = data;
            last_reg  = rd;
        end
        tests++;
        if (bus.out_RegWrite !== we) begin
            fails++;
            $display("FAIL %s write_enable got %b need %b", tag, bus.out_RegWrite, we);
        end
        tests++;
        if (bus.Stall !== 1'b0) begin
            fails++;
            $display("FAIL %s stall got %b need 0", tag, bus.Stall);
        end
        tests++;
        if (bus.out_WriteData !== last_data || bus.out_WriteRegister !== last_reg) begin
            fails++;
            $display("FAIL %s data/reg got %h/%0d need %h/%0d", tag, bus.out_WriteData,
                     bus.out_WriteRegister, last_data, last_reg);
        end
        if (retire) begin
            tests++;
            if (bus.out_ALUMemOrPC !== lk) begin
                fails++;
                $display("FAIL %s link_flag got %b need %b", tag, bus.out_ALUMemOrPC, lk);
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        @(negedge clk);
        tests++;
        if ({bus.out_RegWrite, bus.out_WriteRegister, bus.out_WriteData, bus.out_ALUMemOrPC,
             bus.Stall, bus.LoadError} !== '0) begin
            fails++;
            $display("FAIL reset outputs got we=%b reg=%0d data=%h lk=%b st=%b le=%b need all 0",
                     bus.out_RegWrite, bus.out_WriteRegister, bus.out_WriteData,
                     bus.out_ALUMemOrPC, bus.Stall, bus.LoadError);
        end
        reset = 0;
        last_data = '0; last_reg = '0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        run_instr("alu_r5", 1, 0, 1, 0, 0, 5'd5, 32'h0000_1234, $urandom, $urandom, 0);
    endtask

    task automatic test_load();
        run_instr("load_r8_late3", 1, 0, 1, 1, 0, 5'd8, $urandom, $urandom, 32'hDEAD_BEEF, 3);
        // One cycle later the single write pulse must be gone.
        @(posedge clk); @(negedge clk);
        tests++;
        if (bus.out_RegWrite !== 1'b0) begin
            fails++;
            $display("FAIL load_single_pulse got %b need 0", bus.out_RegWrite);
        end
        run_instr("load_r8_now", 1, 0, 1, 1, 0, 5'd8, $urandom, $urandom, 32'h1357_9BDF, 0);
    endtask

    task automatic test_link();
        run_instr("jal_r31", 1, 0, 1, 0, 1, 5'd31, $urandom, 32'h0040_0008, $urandom, 0);
        run_instr("jal_r0",  1, 0, 1, 0, 1, 5'd0,  $urandom, 32'h0040_0010, $urandom, 0);
    endtask

    task automatic test_r0_flush();
        run_instr("alu_r0",     1, 0, 1, 0, 0, 5'd0, 32'hFFFF_0001, $urandom, $urandom, 0);
        run_instr("flush_r9",   1, 1, 1, 0, 0, 5'd9, 32'h0000_0099, $urandom, $urandom, 0);
        run_instr("flush_load", 1, 1, 1, 1, 0, 5'd9, $urandom, $urandom, 32'hBAD0_BAD0, 0);
        run_instr("bubble",     0, 0, 1, 0, 0, 5'd4, $urandom, $urandom, $urandom, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            logic v, fl, m2r;
            v   = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            m2r = 1'($urandom);
            run_instr($sformatf("rand%0d", i), v, fl, 1'($urandom), m2r,
                      ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)),
                      $urandom, $urandom, $urandom, $urandom_range(0, 5));
        end
        tests++;
        if (bus.LoadError !== 1'b0) begin
            fails++;
            $display("FAIL rand_no_load_error got %b need 0", bus.LoadError);
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        logic [31:0] in1, in2, pc;
        in1 = $urandom; in2 = $urandom; pc = $urandom;
        bus.ReadRegister1 = 5'd3; bus.ReadRegister2 = 5'd0;
        bus.ReadData1In = in1; bus.ReadData2In = in2;
        bus.in_valid = 1; bus.in_RegWrite = 1; bus.in_WriteRegister = 5'd3;
        bus.in_ALUResult = 32'hCAFE_0000;
        @(posedge clk); @(negedge clk);
        drive_idle();
        last_data = 32'hCAFE_0000; last_reg = 5'd3;
        tests++;
        if (bus.ReadData1Bypass !== 32'hCAFE_0000) begin
            fails++;
            $display("FAIL bypass_r3 got %h need cafe0000", bus.ReadData1Bypass);
        end
        tests++;
        if (bus.ReadData2Bypass !== in2) begin
            fails++;
            $display("FAIL bypass_r0 got %h need %h", bus.ReadData2Bypass, in2);
        end
        bus.ReadRegister1 = 5'd4; #1;
        tests++;
        if (bus.ReadData1Bypass !== in1) begin
            fails++;
            $display("FAIL bypass_miss got %h need %h", bus.ReadData1Bypass, in1);
        end
        // Link: effective destination is r31, not the encoded field.
        bus.in_valid = 1; bus.in_RegWrite = 1; bus.in_ALUMemOrPC = 1;
        bus.in_WriteRegister = 5'd7; bus.in_PCPlus4 = pc;
        @(posedge clk); @(negedge clk);
        drive_idle();
        last_data = pc; last_reg = 5'd7;
        bus.ReadRegister1 = 5'd7; bus.ReadRegister2 = 5'd31; #1;
        tests++;
        if (bus.ReadData2Bypass !== pc || bus.ReadData1Bypass !== in1) begin
            fails++;
            $display("FAIL bypass_link got %h/%h need %h/%h", bus.ReadData2Bypass,
                     bus.ReadData1Bypass, pc, in1);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (bus.ReadData2Bypass !== in2) begin
            fails++;
            $display("FAIL bypass_no_write got %h need %h", bus.ReadData2Bypass, in2);
        end
    endtask
`endif

    task automatic test_timeout();
        bus.in_valid = 1; bus.in_RegWrite = 1; bus.in_MemtoReg = 1;
        bus.in_WriteRegister = 5'd10; bus.MemReadValid = 0;
        @(posedge clk); @(negedge clk);
        drive_idle();
        for (int k = 1; k <= TO; k++) begin
            tests++;
            if ({bus.Stall, bus.out_RegWrite} !== 2'b10) begin
                fails++;
                $display("FAIL timeout_wait%0d stall/we got %b%b need 10", k, bus.Stall, bus.out_RegWrite);
            end
            @(posedge clk); @(negedge clk);
        end
        tests++;
        if ({bus.Stall, bus.LoadError, bus.out_RegWrite} !== 3'b010 || bus.out_WriteData !== last_data) begin
            fails++;
            $display("FAIL timeout_end st/le/we got %b%b%b data %h need 010 data %h",
                     bus.Stall, bus.LoadError, bus.out_RegWrite, bus.out_WriteData, last_data);
        end
        // Repeat, then reset in the middle of the wait.
        bus.in_valid = 1; bus.in_RegWrite = 1; bus.in_MemtoReg = 1; bus.in_WriteRegister = 5'd11;
        @(posedge clk); @(negedge clk);
        drive_idle();
        for (int k = 0; k < 4; k++) begin @(posedge clk); @(negedge clk); end
        tests++;
        if (bus.Stall !== 1'b1) begin
            fails++;
            $display("FAIL midwait_stall got %b need 1", bus.Stall);
        end
        reset = 1; #1;
        tests++;
        if ({bus.out_RegWrite, bus.out_WriteRegister, bus.out_WriteData, bus.out_ALUMemOrPC,
             bus.Stall, bus.LoadError} !== '0) begin
            fails++;
            $display("FAIL midwait_reset got we=%b reg=%0d data=%h lk=%b st=%b le=%b need all 0",
                     bus.out_RegWrite, bus.out_WriteRegister, bus.out_WriteData,
                     bus.out_ALUMemOrPC, bus.Stall, bus.LoadError);
        end
        @(negedge clk);
        reset = 0;
        last_data = '0; last_reg = '0;
        run_instr("after_reset", 1, 0, 1, 0, 0, 5'd12, 32'h0BAD_F00D, $urandom, $urandom, 0);
    endtask

    initial begin
        drive_idle();
`ifdef WB_BYPASS_EN
        bus.ReadRegister1 = 0; bus.ReadRegister2 = 0; bus.ReadData1In = 0; bus.ReadData2In = 0;
`endif
        test_reset();
        test_alu();
        test_load();
        test_link();
        test_r0_flush();
        test_back_to_back();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
